// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch responder.
// Contents:
//   state_t    - fetch FSM states (IDLE, ISSUE, WAIT)
//   NOP_INSTR  - ADDI x0,x0,0, the instruction presented after reset or flush
//   ADDR_W_DEF - default byte-address width of the memory bus
//   PC_W       - word-address width for the default bus width
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          ADDR_W_DEF = 32;
  localparam int          PC_W       = ADDR_W_DEF - 2;

endpackage

// File: rtl/imem_fetch_responder.sv
// Instruction-side fetch responder.
// Returns the instruction for the PC unit's word address from a single-entry
// address/instruction buffer. On a miss the buffer is filled over a
// valid/ready request + valid response memory bus, and stall is held high
// until the buffered word matches pc.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   pc             in   requested word address (ADDR_WIDTH-2 bits)
//   flush          in   invalidate the buffer (fence.i / redirect)
//   instr          out  buffered instruction, valid for pc when stall=0
//   stall          out  1 while the buffer does not hold pc
//   mem_req_valid  out  memory request valid (registered)
//   mem_req_ready  in   memory accepts the request
//   mem_req_addr   out  request byte address {req_addr, 2'b00} (registered)
//   mem_resp_valid in   memory response valid
//   mem_resp_data  in   memory response data
//
// States:
//   IDLE  | no request outstanding; a miss launches a request for pc
//   ISSUE | request presented, waiting for mem_req_ready
//   WAIT  | request accepted, waiting for mem_resp_valid
module imem_fetch_responder
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_INSTR = DATA_WIDTH'(NOP_INSTR)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-3:0]   pc,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic                    stall,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

  localparam int PCW = ADDR_WIDTH - 2;

  state_t                state_q, state_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [PCW-1:0]        buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [PCW-1:0]        req_addr_q, req_addr_d;
  logic                  drop_q, drop_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  hit;

  assign hit           = buf_valid_q && (buf_addr_q == pc);
  assign stall         = !hit;
  assign instr         = buf_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = {req_addr_q, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      buf_valid_q     <= 1'b0;
      buf_addr_q      <= '0;
      buf_data_q      <= RESET_INSTR;
      req_addr_q      <= '0;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_valid_q     <= buf_valid_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      req_addr_q      <= req_addr_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    buf_valid_d     = buf_valid_q;
    buf_addr_d      = buf_addr_q;
    buf_data_d      = buf_data_q;
    req_addr_d      = req_addr_q;
    drop_d          = drop_q;
    mem_req_valid_d = mem_req_valid_q;

    if (flush) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!hit && !flush) begin
          req_addr_d      = pc;
          mem_req_valid_d = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        // The request stays up with a fixed address until accepted; a flush
        // here only marks the eventual response as stale.
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          // Stale data is still written, but left invalid so IDLE refetches.
          buf_data_d  = mem_resp_data;
          buf_addr_d  = req_addr_q;
          buf_valid_d = !(drop_q || flush);
          drop_d      = 1'b0;
          state_d     = IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
